imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, sets the program memory address width.
REQ-002 Parameter DATA_W, default 8, sets the instruction/data word width (opcode[7:4], operand[3:0]).
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 fetch_req  in  1  CPU fetch request from controller_fsm; held until fetch_gnt.
REQ-006 fetch_addr  in  ADDR_W  PC value to fetch.
REQ-007 fetch_gnt  out  1  fetch issued to memory this cycle.
REQ-008 fetch_valid / fetch_data  out  1 / DATA_W  instruction returned; feeds IR when LoadIR.
REQ-009 stall  out  1  holds controller_fsm state; equals fetch_req AND NOT fetch_gnt.
REQ-010 ld_req, ld_we  in  1, 1  loader/debug access request and write enable; held until ld_gnt.
REQ-011 ld_addr / ld_wdata  in  ADDR_W / DATA_W  loader address and write data.
REQ-012 ld_gnt, ld_valid / ld_rdata  out  1, 1 / DATA_W  loader grant; loader read return.
REQ-013 mem_en, mem_we  out  1, 1  single-port synchronous memory strobe and write enable.
REQ-014 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and write data.
REQ-015 mem_rdata  in  DATA_W  read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-016 At most one memory access per cycle; a grant and mem_en are asserted combinationally in the same cycle N.
REQ-017 Read latency: fetch_valid or ld_valid pulses exactly in cycle N+1 with data = mem_rdata; writes produce no valid pulse.
REQ-018 Base arbitration: fixed priority, loader over fetch, evaluated every cycle; a new grant may issue in the same cycle a previous read returns (back-to-back, one access/cycle).
REQ-019 In-flight tracker FSM states: NONE, FETCH_RD, LOAD_RD; next state = FETCH_RD on fetch grant, LOAD_RD on loader read grant, NONE otherwise (including loader write).
REQ-020 mem_addr/mem_wdata/mem_we follow the granted requester; all zero when no grant.
REQ-021 No requests: mem_en=0, all grants 0, stall=0; FSM goes to NONE.
REQ-022 Simultaneous requests: only one grant per cycle; the losing requester sees no grant and must keep its request and fields stable.
REQ-023 Requests deasserted without a grant are dropped silently; a granted read always returns its valid pulse unless reset intervenes.
REQ-024 fetch_data and ld_rdata are registered and hold their last returned value between valid pulses.

Reset
REQ-025 reset low asynchronously forces FSM=NONE, fetch_valid=0, ld_valid=0, fetch_data=0, ld_rdata=0, starvation counter=0.
REQ-026 While reset is low, all grants, mem_en, mem_we and stall are 0 regardless of requests.
REQ-027 A read in flight when reset asserts is discarded; no valid pulse follows reset release.
REQ-028 First grant is possible in the first rising edge cycle after reset deasserts.

Configuration
REQ-029 Macro FETCH_STARVE_GUARD_EN compiles in a 3-bit starvation counter counting consecutive loader grants while fetch_req is high.
REQ-030 With FETCH_STARVE_GUARD_EN: when the counter reaches 4, fetch wins the next conflict; the counter clears on fetch grant or when fetch_req is low.
REQ-031 Without FETCH_STARVE_GUARD_EN: pure loader priority; fetch may stall indefinitely; no counter logic exists.

Structure
REQ-032 Shared package cpu_pkg holds ADDR_W/DATA_W defaults, in-flight state encoding (NONE=2'b00, FETCH_RD=2'b01, LOAD_RD=2'b10) and starvation limit constant 4.
REQ-033 Sub-module imem_starve_guard contains the starvation counter and is instantiated only under FETCH_STARVE_GUARD_EN.

Verification
REQ-034 fetch_req=1, fetch_addr=8'h05, mem holds 8'h1D at 5 -> fetch_gnt in cycle N, fetch_valid=1 and fetch_data=8'h1D in N+1, stall=0.
REQ-035 ld_req=1, ld_we=1, ld_addr=8'h10, ld_wdata=8'hA7, then loader read of 8'h10 -> ld_valid=1, ld_rdata=8'hA7 one cycle after read grant.
REQ-036 fetch_req and ld_req both held for 6 cycles (loader reads) -> without macro fetch_gnt=0 and stall=1 for all 6; with macro fetch_gnt=1 in cycle 5.
REQ-037 Back-to-back fetches of addrs 0,1,2 -> three consecutive fetch_gnt cycles, fetch_valid high three consecutive cycles with matching data.
REQ-038 reset driven low in the cycle after a fetch grant -> no fetch_valid pulse, all outputs 0 until release; next fetch completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction-memory arbiter slice:
//   - default address/data widths for the program memory
//   - encoding of the in-flight read tracker state
//   - starvation limit for the optional fetch starvation guard
//     (compiled in with macro FETCH_STARVE_GUARD_EN)
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;

  // Consecutive loader grants tolerated while fetch waits.
  localparam int STARVE_LIMIT = 4;
  localparam int STARVE_CNT_W = 3;

  // Which requester owns the read currently returning from memory.
  typedef enum logic [1:0] {
    NONE     = 2'b00,
    FETCH_RD = 2'b01,
    LOAD_RD  = 2'b10
  } inflight_e;

  function automatic logic starveHit(input logic [STARVE_CNT_W-1:0] cnt);
    return cnt >= STARVE_CNT_W'(STARVE_LIMIT);
  endfunction

endpackage

// File: rtl/imem_starve_guard.sv
// ----------------------------------------------------------------------------
// imem_starve_guard
// Counts consecutive loader grants taken while the CPU fetch is waiting and
// raises fetch_prio_o once the limit is reached, so that fetch wins the next
// conflict. Only instantiated when FETCH_STARVE_GUARD_EN is defined.
//
// Ports:
//   Clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   fetch_req_i  in   CPU fetch request
//   fetch_gnt_i  in   fetch granted this cycle
//   ld_gnt_i     in   loader granted this cycle
//   fetch_prio_o out  fetch takes precedence on the next conflict
// ----------------------------------------------------------------------------
module imem_starve_guard
  import cpu_pkg::*;
(
  input  logic Clk,
  input  logic reset,
  input  logic fetch_req_i,
  input  logic fetch_gnt_i,
  input  logic ld_gnt_i,
  output logic fetch_prio_o
);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // The count only means something while fetch is actually waiting, so it
  // clears whenever fetch drops its request or finally gets served. It
  // saturates at the limit rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (!fetch_req_i || fetch_gnt_i) begin
      cnt_d = '0;
    end else if (ld_gnt_i && !starveHit(cnt_q)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_prio_o = starveHit(cnt_q);

endmodule

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter
// Arbitrates a single-port synchronous program memory between the CPU fetch
// path and a loader/debug port. One access per cycle; grant and mem_en are
// combinational in the access cycle, read data returns one cycle later.
// Loader has fixed priority over fetch. Defining FETCH_STARVE_GUARD_EN adds
// a starvation guard (imem_starve_guard) that lets fetch win a conflict after
// STARVE_LIMIT consecutive loader grants.
//
// Ports:
//   Clk, reset                   clock / asynchronous active-low reset
//   fetch_req, fetch_addr        CPU fetch request and PC
//   fetch_gnt, stall             fetch issued this cycle / fetch waiting
//   fetch_valid, fetch_data      fetched instruction return
//   ld_req, ld_we, ld_addr,
//   ld_wdata                     loader access request
//   ld_gnt, ld_valid, ld_rdata   loader grant and read return
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata         memory interface
// ----------------------------------------------------------------------------
module imem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  inflight_e         state_q;
  inflight_e         state_d;
  logic [DATA_W-1:0] fetchData_q;
  logic [DATA_W-1:0] ldRdata_q;
  logic              gntFetch;
  logic              gntLoad;
  logic              fetchPrio;

`ifdef FETCH_STARVE_GUARD_EN
  imem_starve_guard u_starve_guard (
    .Clk          (Clk),
    .reset        (reset),
    .fetch_req_i  (fetch_req),
    .fetch_gnt_i  (gntFetch),
    .ld_gnt_i     (gntLoad),
    .fetch_prio_o (fetchPrio)
  );
`else
  assign fetchPrio = 1'b0;
`endif

  // Grants are qualified with reset so nothing reaches memory while the
  // block is held in reset, even though the requests are combinational.
  always_comb begin
    gntFetch = 1'b0;
    gntLoad  = 1'b0;
    if (reset) begin
      if (ld_req && fetch_req) begin
        if (fetchPrio) begin
          gntFetch = 1'b1;
        end else begin
          gntLoad = 1'b1;
        end
      end else if (ld_req) begin
        gntLoad = 1'b1;
      end else if (fetch_req) begin
        gntFetch = 1'b1;
      end
    end
  end

  // Tracks whose read comes back next cycle; loader writes return nothing.
  always_comb begin
    state_d = NONE;
    if (gntFetch) begin
      state_d = FETCH_RD;
    end else if (gntLoad && !ld_we) begin
      state_d = LOAD_RD;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= NONE;
      fetchData_q <= '0;
      ldRdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH_RD) begin
        fetchData_q <= mem_rdata;
      end
      if (state_q == LOAD_RD) begin
        ldRdata_q <= mem_rdata;
      end
    end
  end

  assign fetch_gnt   = gntFetch;
  assign ld_gnt      = gntLoad;
  assign stall       = reset & fetch_req & ~gntFetch;

  assign mem_en      = gntFetch | gntLoad;
  assign mem_we      = gntLoad & ld_we;
  assign mem_addr    = gntFetch ? fetch_addr : (gntLoad ? ld_addr : '0);
  assign mem_wdata   = gntLoad ? ld_wdata : '0;

  // The memory's output register provides the return-cycle data; our own
  // register takes over afterwards so the outputs hold between pulses.
  assign fetch_valid = (state_q == FETCH_RD);
  assign ld_valid    = (state_q == LOAD_RD);
  assign fetch_data  = fetch_valid ? mem_rdata : fetchData_q;
  assign ld_rdata    = ld_valid ? mem_rdata : ldRdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_imem_arbiter
// Self-checking bench for imem_arbiter with a behavioural synchronous memory.
// Expected grants come from a vector table; expected read returns are pushed
// to a scoreboard queue at grant time and popped in the return cycle.
// Honours FETCH_STARVE_GUARD_EN for the starvation sequence.
// ----------------------------------------------------------------------------
module tb_imem_arbiter;

  logic       Clk;
  logic       reset;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_gnt;
  logic       fetch_valid;
  logic [7:0] fetch_data;
  logic       stall;
  logic       ld_req;
  logic       ld_we;
  logic [7:0] ld_addr;
  logic [7:0] ld_wdata;
  logic       ld_gnt;
  logic       ld_valid;
  logic [7:0] ld_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  imem_arbiter dut (
    .Clk         (Clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .stall       (stall),
    .ld_req      (ld_req),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .ld_gnt      (ld_gnt),
    .ld_valid    (ld_valid),
    .ld_rdata    (ld_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] memModel [256];
  logic [7:0] refMem   [256];

  // Behavioural single-port synchronous memory.
  always @(posedge Clk) begin
    if (mem_en) begin
      if (mem_we) begin
        memModel[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= memModel[mem_addr];
      end
    end
  end

  typedef struct {
    logic       fReq;
    logic [7:0] fAddr;
    logic       lReq;
    logic       lWe;
    logic [7:0] lAddr;
    logic [7:0] lWdata;
    logic       eFGnt;
    logic       eLGnt;
    logic       eStall;
  } vec_t;

  typedef struct {
    int         due;
    logic       fv;
    logic       lv;
    logic [7:0] data;
  } exp_t;

  exp_t expQ [$];
  int   vecCount  = 0;
  int   missCount = 0;
  int   curCycle  = 0;
  logic [7:0] lastFetch = 8'h00;
  logic [7:0] lastLd    = 8'h00;
  vec_t table_v [13];

  function automatic vec_t mkVec(logic fr, logic [7:0] fa, logic lr, logic lw,
                                 logic [7:0] la, logic [7:0] ld,
                                 logic ef, logic el, logic es);
    vec_t v;
    v.fReq = fr; v.fAddr = fa; v.lReq = lr; v.lWe = lw;
    v.lAddr = la; v.lWdata = ld;
    v.eFGnt = ef; v.eLGnt = el; v.eStall = es;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, required %0h", nm, curCycle, act, exp);
    end
  endtask

  // Compares the cycle's combinational outputs and the scoreboard, then
  // records any read return expected next cycle.
  task automatic checkOutput(input vec_t v, input string nm);
    exp_t e;
    logic [7:0] eAddr;
    eAddr = v.eFGnt ? v.fAddr : (v.eLGnt ? v.lAddr : 8'h00);
    check({nm, ".fetch_gnt"}, 8'(fetch_gnt), 8'(v.eFGnt));
    check({nm, ".ld_gnt"},    8'(ld_gnt),    8'(v.eLGnt));
    check({nm, ".stall"},     8'(stall),     8'(v.eStall));
    check({nm, ".mem_en"},    8'(mem_en),    8'(v.eFGnt | v.eLGnt));
    check({nm, ".mem_we"},    8'(mem_we),    8'(v.eLGnt & v.lWe));
    check({nm, ".mem_addr"},  mem_addr,      eAddr);
    check({nm, ".mem_wdata"}, mem_wdata,     v.eLGnt ? v.lWdata : 8'h00);
    if (expQ.size() > 0 && expQ[0].due == curCycle) begin
      e = expQ.pop_front();
      if (e.fv) lastFetch = e.data;
      if (e.lv) lastLd = e.data;
      check({nm, ".fetch_valid"}, 8'(fetch_valid), 8'(e.fv));
      check({nm, ".ld_valid"},    8'(ld_valid),    8'(e.lv));
    end else begin
      check({nm, ".fetch_valid"}, 8'(fetch_valid), 8'h00);
      check({nm, ".ld_valid"},    8'(ld_valid),    8'h00);
    end
    check({nm, ".fetch_data"}, fetch_data, lastFetch);
    check({nm, ".ld_rdata"},   ld_rdata,   lastLd);
    if (v.eFGnt) begin
      e.due = curCycle + 1; e.fv = 1'b1; e.lv = 1'b0; e.data = refMem[v.fAddr];
      expQ.push_back(e);
    end else if (v.eLGnt && !v.lWe) begin
      e.due = curCycle + 1; e.fv = 1'b0; e.lv = 1'b1; e.data = refMem[v.lAddr];
      expQ.push_back(e);
    end else if (v.eLGnt && v.lWe) begin
      refMem[v.lAddr] = v.lWdata;
    end
  endtask

  // Entered #1 after a rising edge; leaves #1 after the next rising edge.
  task automatic applyStimulus(input vec_t v, input string nm);
    fetch_req  = v.fReq;
    fetch_addr = v.fAddr;
    ld_req     = v.lReq;
    ld_we      = v.lWe;
    ld_addr    = v.lAddr;
    ld_wdata   = v.lWdata;
    @(negedge Clk);
    checkOutput(v, nm);
    curCycle++;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkAllZero(input string nm);
    check({nm, ".fetch_gnt"},   8'(fetch_gnt),   8'h00);
    check({nm, ".ld_gnt"},      8'(ld_gnt),      8'h00);
    check({nm, ".stall"},       8'(stall),       8'h00);
    check({nm, ".mem_en"},      8'(mem_en),      8'h00);
    check({nm, ".mem_we"},      8'(mem_we),      8'h00);
    check({nm, ".fetch_valid"}, 8'(fetch_valid), 8'h00);
    check({nm, ".ld_valid"},    8'(ld_valid),    8'h00);
    check({nm, ".fetch_data"},  fetch_data,      8'h00);
    check({nm, ".ld_rdata"},    ld_rdata,        8'h00);
  endtask

  initial begin
    vec_t v;
    logic ef;
    logic el;

    for (int i = 0; i < 256; i++) begin
      memModel[i] = 8'(i * 37 + 11);
      refMem[i]   = 8'(i * 37 + 11);
    end
    memModel[5] = 8'h1D;
    refMem[5]   = 8'h1D;
    mem_rdata   = 8'h00;

    //                  fReq fAddr  lReq lWe lAddr  lWdata eF eL eS
    table_v[0]  = mkVec(1, 8'h05, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    table_v[1]  = mkVec(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    table_v[2]  = mkVec(0, 8'h00, 1, 1, 8'h10, 8'hA7, 0, 1, 0);
    table_v[3]  = mkVec(0, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1, 0);
    table_v[4]  = mkVec(1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    table_v[5]  = mkVec(1, 8'h01, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    table_v[6]  = mkVec(1, 8'h02, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    table_v[7]  = mkVec(1, 8'h03, 1, 0, 8'h05, 8'h00, 0, 1, 1);
    table_v[8]  = mkVec(1, 8'h03, 1, 1, 8'h20, 8'h55, 0, 1, 1);
    table_v[9]  = mkVec(1, 8'h03, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    table_v[10] = mkVec(0, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 0);
    table_v[11] = mkVec(1, 8'h20, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    table_v[12] = mkVec(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = 8'h05;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h40; ld_wdata = 8'hEE;
    #2;
    checkAllZero("reset");
    @(posedge Clk);
    #1;
    checkAllZero("reset_held");
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(table_v[i], $sformatf("vec%0d", i));
    end

    // Both requesters held for six cycles.
    for (int i = 1; i <= 6; i++) begin
`ifdef FETCH_STARVE_GUARD_EN
      ef = (i == 5);
`else
      ef = 1'b0;
`endif
      el = ~ef;
      v = mkVec(1, 8'h07, 1, 0, 8'h08, 8'h00, ef, el, ~ef);
      applyStimulus(v, $sformatf("starve%0d", i));
    end
    applyStimulus(mkVec(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0), "starve_idle");

    // Reset lands on an in-flight fetch; the read must be discarded.
    applyStimulus(mkVec(1, 8'h09, 0, 0, 8'h00, 8'h00, 1, 0, 0), "pre_reset");
    reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = 8'h06;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h30; ld_wdata = 8'hFF;
    expQ.delete();
    lastFetch = 8'h00;
    lastLd    = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      checkAllZero($sformatf("in_reset%0d", i));
      curCycle++;
      @(posedge Clk);
      #1;
    end
    reset = 1'b1;
    applyStimulus(mkVec(1, 8'h05, 0, 0, 8'h00, 8'h00, 1, 0, 0), "post_reset_fetch");
    applyStimulus(mkVec(1, 8'h30, 0, 0, 8'h00, 8'h00, 1, 0, 0), "post_reset_30");
    applyStimulus(mkVec(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0), "final_idle");

    check("scoreboard_empty", 8'(expQ.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
